ec1_led_counter: RTL and testbench
==================================

// Module: ec1_led_counter
// PURPOSE
//  Loadable up-counter that drives an 8-bit LED bank and raises a terminal flag.
//  - After reset release it captures an 8-bit target from switch input A.
//  - It shows a running count on led, stops at the target and holds H high.
//  - Leaf block of the board-level demo, between the switch bank and the LEDs.
// PARAMETERS
//  WIDTH     8  width of A, led, count and target registers
//  TICK_DIV  1  clock cycles per count step (1 = every cycle; must be >= 1)
// PORTS
//  clk    in   1      single system clock; all logic on its rising edge
//  Reset  in   1      synchronous, active-low reset (0 = reset, sampled on clk)
//  A      in   WIDTH  target count, sampled only in IDLE
//  led    out  WIDTH  current count value, registered
//  H      out  1      done flag, registered; 1 while count == target
// BEHAVIOUR
//  Reset
//  - Reset==0 at a clk edge forces state=IDLE, led=0, H=0, target=0, prescaler=0.
//  - Reset has priority over every other action, including mid-count and in DONE.
//  Tick
//  - Prescaler counts 0..TICK_DIV-1 in COUNT only; tick=1 when it equals TICK_DIV-1.
//  - The prescaler wraps to 0 on tick. With TICK_DIV=1, tick=1 every COUNT cycle.
//  States: IDLE -> COUNT -> DONE
//  - IDLE: one cycle after reset release. target<=A.
//    - A==0: go to DONE with H<=1, led stays 0.
//    - Otherwise go to COUNT.
//  - COUNT: on tick, led<=led+1.
//    - If led+1==target, go to DONE and H<=1 on the same edge.
//    - led and H update together, so there is never a cycle with led==target and H==0.
//  - DONE: led and H hold. A is ignored. Leave DONE only via reset.
//  Latency and limits
//  - TICK_DIV=1: H rises at the (N+1)th rising edge after the first edge with Reset==1.
//    N = A value latched in IDLE.
//  - Count never wraps. Maximum target 2^WIDTH-1 gives 255 steps, and led stops at 8'hFF.
//  - A changes during COUNT or DONE have no effect. A new target requires a reset pulse.
//  - H never pulses; it is level-held until reset.
// TESTING
//  1. Hold Reset=0 for 5 cycles, A=8'h00 -> led=0, H=0 every cycle.
//     Release -> edge 1: led=0, H=1.
//  2. A=8'h01, release reset -> edge 1: led=0, H=0; edge 2: led=1, H=1.
//     Holds for 50 more cycles.
//  3. A=8'h03, release, change A to 8'h10 at edge 2 -> led 0,1,2,3.
//     H=1 at edge 4; led stays 3 (target latched).
//  4. A=8'h04, reset asserted at edge 3 (led=2) -> led=0, H=0 next edge.
//     On re-release it counts to 4, H at edge 5.
//  5. A=8'hFF for 100 cycles -> led increments each cycle to 99, H=0.
//     Extended to 300 cycles -> led stops at 8'hFF, H=1 at edge 256, no wrap.
//  6. TICK_DIV=4, A=8'h02 -> led steps every 4 cycles; H=1 with led=2 at edge 9.

Source files
------------

// File: rtl/ec1_led_counter.sv
// Loadable LED up-counter: latches a target from A after reset release, counts led
// up to it at one step per TICK_DIV cycles, then holds led and raises H until reset.
module ec1_led_counter #(
   parameter int WIDTH    = 8,
   parameter int TICK_DIV = 1
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] led,
   output logic             H
);

   // state | meaning
   // IDLE  | first cycle after reset release; latch target from A
   // COUNT | step led on each prescaler tick until it reaches target
   // DONE  | led == target, H held high; exit only through reset
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] led_q, led_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             h_q, h_d;
   logic             tick;
   logic [WIDTH-1:0] led_inc;

   assign tick    = (presc_q == PRESC_LAST);
   assign led_inc = led_q + WIDTH'(1);

   always_comb begin
      state_d  = state_q;
      led_d    = led_q;
      target_d = target_q;
      presc_d  = '0;
      h_d      = h_q;
      case (state_q)
         IDLE: begin
            target_d = A;
            if (A == '0) begin
               state_d = DONE;
               h_d     = 1'b1;
            end else begin
               state_d = COUNT;
            end
         end
         COUNT: begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
               led_d = led_inc;
               // led and H change on the same edge so led==target never shows with H low
               if (led_inc == target_q) begin
                  state_d = DONE;
                  h_d     = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!Reset) begin
         state_q  <= IDLE;
         led_q    <= '0;
         target_q <= '0;
         presc_q  <= '0;
         h_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         led_q    <= led_d;
         target_q <= target_d;
         presc_q  <= presc_d;
         h_q      <= h_d;
      end
   end

   assign led = led_q;
   assign H   = h_q;

endmodule

// File: tb/tb_ec1_led_counter.sv
// Bench for ec1_led_counter: directed vector tables plus randomized runs against a
// closed-form model (led = min(target, (edges since release - 1) / TICK_DIV)).
module tb_ec1_led_counter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_b, rst4_b;
   logic [7:0] a, a4, led, led4;
   logic       h, h4;

   ec1_led_counter #(.WIDTH(8), .TICK_DIV(1)) dut (
      .clk(clk), .Reset(rst_b), .A(a), .led(led), .H(h));

   ec1_led_counter #(.WIDTH(8), .TICK_DIV(4)) dut4 (
      .clk(clk), .Reset(rst4_b), .A(a4), .led(led4), .H(h4));

   typedef struct {
      logic       rst;
      logic [7:0] a;
      logic [7:0] led;
      logic       h;
   } vec_t;

   vec_t       tv[$];
   int         passed = 0;
   int         total  = 0;
   int         k1 = 0, k4 = 0;
   logic [7:0] n1 = 8'h00, n4 = 8'h00;

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got H/led=%0h required %0h at t=%0t", name, act, exp, $time);
   endtask

   // k = edges since the first edge with Reset high; n = A seen on that first edge
   function automatic logic [8:0] model(input int k, input logic [7:0] n, input int d);
      int l;
      if (k == 0) return 9'h000;
      l = (k - 1) / d;
      if (l > int'(n)) l = int'(n);
      return {(l == int'(n)), 8'(l)};
   endfunction

   task automatic step();
      @(posedge clk);
      if (!rst_b) k1 = 0;
      else begin
         k1++;
         if (k1 == 1) n1 = a;
      end
      if (!rst4_b) k4 = 0;
      else begin
         k4++;
         if (k4 == 1) n4 = a4;
      end
      #1;
      check("model_div1", {h, led}, model(k1, n1, 1));
      check("model_div4", {h4, led4}, model(k4, n4, 4));
   endtask

   task automatic add(input logic r, input logic [7:0] av, input logic [7:0] l, input logic hv);
      vec_t v;
      v.rst = r; v.a = av; v.led = l; v.h = hv;
      tv.push_back(v);
   endtask

   initial begin
      rst_b = 1'b0; a = 8'h00; rst4_b = 1'b0; a4 = 8'h00;

      // A=0: held reset, then H immediately on release
      for (int i = 0; i < 5; i++) add(1'b0, 8'h00, 8'h00, 1'b0);
      add(1'b1, 8'h00, 8'h00, 1'b1);
      add(1'b1, 8'h55, 8'h00, 1'b1);
      // A=1
      add(1'b0, 8'h01, 8'h00, 1'b0);
      add(1'b1, 8'h01, 8'h00, 1'b0);
      add(1'b1, 8'h01, 8'h01, 1'b1);
      // A=3, A changed after latch
      add(1'b0, 8'h03, 8'h00, 1'b0);
      add(1'b1, 8'h03, 8'h00, 1'b0);
      add(1'b1, 8'h10, 8'h01, 1'b0);
      add(1'b1, 8'h10, 8'h02, 1'b0);
      add(1'b1, 8'h10, 8'h03, 1'b1);
      add(1'b1, 8'h10, 8'h03, 1'b1);
      // A=4, reset mid-count then full run
      add(1'b0, 8'h04, 8'h00, 1'b0);
      add(1'b1, 8'h04, 8'h00, 1'b0);
      add(1'b1, 8'h04, 8'h01, 1'b0);
      add(1'b1, 8'h04, 8'h02, 1'b0);
      add(1'b0, 8'h04, 8'h00, 1'b0);
      add(1'b1, 8'h04, 8'h00, 1'b0);
      add(1'b1, 8'h04, 8'h01, 1'b0);
      add(1'b1, 8'h04, 8'h02, 1'b0);
      add(1'b1, 8'h04, 8'h03, 1'b0);
      add(1'b1, 8'h04, 8'h04, 1'b1);
      // reset while in DONE
      add(1'b0, 8'h04, 8'h00, 1'b0);

      for (int i = 0; i < tv.size(); i++) begin
         rst_b = tv[i].rst;
         a     = tv[i].a;
         step();
         check($sformatf("vec%0d", i), {h, led}, {tv[i].h, tv[i].led});
      end

      // A=1 then hold in DONE for 50 cycles with A wiggling
      rst_b = 1'b0; a = 8'h01; step();
      rst_b = 1'b1; step(); step();
      for (int i = 0; i < 50; i++) begin
         a = 8'($urandom);
         step();
         check("done_hold", {h, led}, 9'h101);
      end

      // A=FF: full-range count, no wrap
      rst_b = 1'b0; a = 8'hFF; step();
      rst_b = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         step();
         if (c == 100) check("ff_edge100", {h, led}, {1'b0, 8'd99});
         if (c == 255) check("ff_edge255", {h, led}, {1'b0, 8'hFE});
         if (c == 256) check("ff_edge256", {h, led}, {1'b1, 8'hFF});
         if (c == 300) check("ff_edge300", {h, led}, {1'b1, 8'hFF});
      end

      // TICK_DIV=4, A=2
      rst4_b = 1'b0; a4 = 8'h02; step();
      rst4_b = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 4) check("div4_edge4", {h4, led4}, {1'b0, 8'd0});
         if (c == 5) check("div4_edge5", {h4, led4}, {1'b0, 8'd1});
         if (c == 8) check("div4_edge8", {h4, led4}, {1'b0, 8'd1});
         if (c == 9) check("div4_edge9", {h4, led4}, {1'b1, 8'd2});
         if (c == 12) check("div4_edge12", {h4, led4}, {1'b1, 8'd2});
      end

      // randomized: occasional reset pulses, A mostly small so DONE is reached often
      for (int i = 0; i < 3000; i++) begin
         rst_b  = ($urandom_range(0, 39) != 0);
         rst4_b = ($urandom_range(0, 59) != 0);
         a  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
         a4 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
         step();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
